io_rail_seq_ctrl: RTL

Digital power-sequencing controller for the IO pad ring. It watches per-segment power-good flags from the rail detectors and debounces them. It then releases each ring segment in a fixed order: pad enable first, then retention/isolation removal. The passive rail-short and power cells only tie rails together; this block actively brings the segments they join up and down. It sits in the always-on digital domain, between the analog power-good detectors and the pad-control inputs of each IO segment.

---
 rtl/io_rail_seq_pkg.sv | 19 +
 rtl/io_rail_pg_debounce.sv | 53 +++++
 rtl/io_rail_seq_ctrl.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/io_rail_seq_pkg.sv
// io_rail_seq_pkg: shared state encoding and default parameters for the IO
// rail sequencing controller. The state encodings below are what state_o
// reports to the outside world.
package io_rail_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_PG = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_FAULT   = 3'd4
    } state_e;

    localparam int NUM_SEG_DEF      = 4;
    localparam int DEBOUNCE_CNT_DEF = 200;
    localparam int STEP_DLY_DEF     = 16;
    localparam int TIMEOUT_CYC_DEF  = 4096;

endpackage

// File: rtl/io_rail_pg_debounce.sv
// io_rail_pg_debounce: brings one asynchronous power-good flag into the clk
// domain through a 2-flop synchronizer and qualifies it with a saturating
// run-length counter. Any low synchronized sample restarts the count.
module io_rail_pg_debounce
    import io_rail_seq_pkg::*;
#(
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pg_async_i,
    output logic pg_sync_o,
    output logic pg_stable_o
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on a low sample, otherwise climb and hold at the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync2_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Synchronizer flops and debounce counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
        end else begin
            sync1_q <= pg_async_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign pg_sync_o   = sync2_q;
    assign pg_stable_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/io_rail_seq_ctrl.sv
// io_rail_seq_ctrl: power-sequencing controller for the IO pad ring.
// Waits for every segment's debounced power-good, then releases segments in
// index order (pad enable first, retention removed STEP_DLY cycles later).
// Any synchronized power-good loss while releasing or running latches a fault.
// Optional feature macro: RAILSEQ_TIMEOUT_EN bounds the WAIT_PG dwell to
// TIMEOUT_CYC cycles; without it WAIT_PG waits indefinitely.
module io_rail_seq_ctrl
    import io_rail_seq_pkg::*;
#(
    parameter int NUM_SEG      = NUM_SEG_DEF,
    parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
    parameter int STEP_DLY     = STEP_DLY_DEF
`ifdef RAILSEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC  = TIMEOUT_CYC_DEF
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SEG-1:0] pwr_good_i,
    input  logic               start_i,
    input  logic               clr_fault_i,
    output logic [NUM_SEG-1:0] seg_en_o,
    output logic [NUM_SEG-1:0] seg_ret_o,
    output logic               ready_o,
    output logic               fault_o,
    output logic [2:0]         state_o
);

    localparam int                 STEP_W    = $clog2(STEP_DLY + 1);
    localparam int                 IDX_W     = $clog2(NUM_SEG + 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_DLY - 1);
    localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_SEG - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [NUM_SEG-1:0] SEG_ONE   = {{(NUM_SEG-1){1'b0}}, 1'b1};
    localparam logic [NUM_SEG-1:0] SEG_ALL   = {NUM_SEG{1'b1}};
    localparam logic [NUM_SEG-1:0] SEG_NONE  = {NUM_SEG{1'b0}};

    logic [NUM_SEG-1:0] pg_sync_s;
    logic [NUM_SEG-1:0] pg_stable_s;
    logic               rail_lost_s;
    logic               all_stable_s;

    state_e             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [STEP_W-1:0]  step_q,   step_d;
    logic [NUM_SEG-1:0] seg_en_q, seg_en_d;
    logic [NUM_SEG-1:0] seg_ret_q, seg_ret_d;
    logic               ready_q,  ready_d;
    logic               fault_q,  fault_d;

`ifdef RAILSEQ_TIMEOUT_EN
    localparam int              TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    genvar g;
    for (g = 0; g < NUM_SEG; g++) begin : g_deb
        io_rail_pg_debounce #(
            .DEBOUNCE_CNT (DEBOUNCE_CNT)
        ) u_deb (
            .clk         (clk),
            .rst_n       (rst_n),
            .pg_async_i  (pwr_good_i[g]),
            .pg_sync_o   (pg_sync_s[g]),
            .pg_stable_o (pg_stable_s[g])
        );
    end

    assign rail_lost_s  = ~(&pg_sync_s);
    assign all_stable_s = &pg_stable_s;

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        step_d    = step_q;
        seg_en_d  = seg_en_q;
        seg_ret_d = seg_ret_q;
        ready_d   = ready_q;
        fault_d   = fault_q;
`ifdef RAILSEQ_TIMEOUT_EN
        to_cnt_d  = to_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_WAIT_PG;
`ifdef RAILSEQ_TIMEOUT_EN
                    to_cnt_d = {TO_W{1'b0}};
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_PG: begin
                if (all_stable_s) begin
                    // Entering step 0 also raises the first pad enable.
                    state_d  = ST_RELEASE;
                    idx_d    = {IDX_W{1'b0}};
                    step_d   = {STEP_W{1'b0}};
                    seg_en_d = SEG_ONE;
`ifdef RAILSEQ_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    state_d   = ST_FAULT;
                    seg_en_d  = SEG_NONE;
                    seg_ret_d = SEG_ALL;
                    ready_d   = 1'b0;
                    fault_d   = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_ONE;
`else
                end else begin
                    state_d = ST_WAIT_PG;
`endif
                end
            end
            ST_RELEASE: begin
                if (rail_lost_s) begin
                    state_d   = ST_FAULT;
                    idx_d     = {IDX_W{1'b0}};
                    step_d    = {STEP_W{1'b0}};
                    seg_en_d  = SEG_NONE;
                    seg_ret_d = SEG_ALL;
                    ready_d   = 1'b0;
                    fault_d   = 1'b1;
                end else if (step_q == STEP_LAST) begin
                    // Drop retention on this segment and, in the same edge,
                    // enable the next one (or declare the ring ready).
                    seg_ret_d = seg_ret_q & ~(SEG_ONE << idx_q);
                    step_d    = {STEP_W{1'b0}};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d    = idx_q + IDX_ONE;
                        seg_en_d = seg_en_q | (SEG_ONE << (idx_q + IDX_ONE));
                    end
                end else begin
                    step_d = step_q + STEP_ONE;
                end
            end
            ST_RUN: begin
                if (rail_lost_s) begin
                    state_d   = ST_FAULT;
                    idx_d     = {IDX_W{1'b0}};
                    seg_en_d  = SEG_NONE;
                    seg_ret_d = SEG_ALL;
                    ready_d   = 1'b0;
                    fault_d   = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                // Clear has priority; a concurrent start_i is dropped.
                if (clr_fault_i) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                idx_d     = {IDX_W{1'b0}};
                step_d    = {STEP_W{1'b0}};
                seg_en_d  = SEG_NONE;
                seg_ret_d = SEG_ALL;
                ready_d   = 1'b0;
                fault_d   = 1'b0;
            end
        endcase
    end

    // FSM state, sequencing counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            step_q    <= {STEP_W{1'b0}};
            seg_en_q  <= SEG_NONE;
            seg_ret_q <= SEG_ALL;
            ready_q   <= 1'b0;
            fault_q   <= 1'b0;
`ifdef RAILSEQ_TIMEOUT_EN
            to_cnt_q  <= {TO_W{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            step_q    <= step_d;
            seg_en_q  <= seg_en_d;
            seg_ret_q <= seg_ret_d;
            ready_q   <= ready_d;
            fault_q   <= fault_d;
`ifdef RAILSEQ_TIMEOUT_EN
            to_cnt_q  <= to_cnt_d;
`endif
        end
    end

    assign seg_en_o  = seg_en_q;
    assign seg_ret_o = seg_ret_q;
    assign ready_o   = ready_q;
    assign fault_o   = fault_q;
    assign state_o   = state_q;

endmodule
